// File: rtl/victory_pkg.sv
// victory_pkg: shared types and constants for the
// tug-of-war match tracker.
package victory_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    OVER = 2'd2
  } vm_state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  // active-low, bit order gfedcba
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/victory_match_score_seg7.sv
// score_seg7: one decimal digit to active-low
// seven-segment, with a blanking override.
module score_seg7
  import victory_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // digit decode; blank wins over any digit
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/victory_match.sv
// victory_match: round-win detection, scoring,
// between-round hold and match decision.
module victory_match
  import victory_pkg::*;
#(
  parameter int WINS_TO_MATCH = 3,
  parameter int HOLD_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       L,
  input  logic       R,
  input  logic       Llight,
  input  logic       Rlight,
  output logic       round_clear,
  output logic       match_over,
  output logic [1:0] winner,
  output logic [6:0] hexL,
  output logic [6:0] hexR
);

  localparam int SW = $clog2(WINS_TO_MATCH + 1);
  localparam int HW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [SW-1:0] WIN_CNT =
    SW'(WINS_TO_MATCH);
  localparam logic [HW-1:0] HOLD_LOAD =
    HW'(HOLD_CYCLES - 1);

  vm_state_t       state_q, state_d;
  logic [HW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   score_l_q, score_l_d;
  logic [SW-1:0]   score_r_q, score_r_d;
  logic [1:0]      winner_q, winner_d;
  logic            over_q, over_d;

  logic            left_win;
  logic            right_win;
  logic [SW-1:0]   score_l_inc;
  logic [SW-1:0]   score_r_inc;
  logic            blank_l;
  logic            blank_r;

  assign left_win    = Llight & L & ~R;
  assign right_win   = Rlight & R & ~L;
  assign score_l_inc = score_l_q + SW'(1);
  assign score_r_inc = score_r_q + SW'(1);

  // next-state, counter and score update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    winner_d  = winner_q;
    over_d    = over_q;
    unique case (state_q)
      PLAY: begin
        unique case (1'b1)
          left_win: begin
            score_l_d = score_l_inc;
            if (score_l_inc == WIN_CNT) begin
              state_d  = OVER;
              winner_d = WIN_LEFT;
              over_d   = 1'b1;
            end else begin
              state_d = HOLD;
              cnt_d   = HOLD_LOAD;
            end
          end
          right_win: begin
            score_r_d = score_r_inc;
            if (score_r_inc == WIN_CNT) begin
              state_d  = OVER;
              winner_d = WIN_RIGHT;
              over_d   = 1'b1;
            end else begin
              state_d = HOLD;
              cnt_d   = HOLD_LOAD;
            end
          end
          default: ;
        endcase
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = PLAY;
        end else begin
          cnt_d = cnt_q - HW'(1);
        end
      end
      OVER: ;
      default: state_d = PLAY;
    endcase
  end

  // state registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= PLAY;
      cnt_q     <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
      winner_q  <= WIN_NONE;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      winner_q  <= winner_d;
      over_q    <= over_d;
    end
  end

  assign round_clear =
    (state_q == HOLD) && (cnt_q == '0);
  assign match_over  = over_q;
  assign winner      = winner_q;

  assign blank_l =
    (state_q == OVER) && (winner_q == WIN_RIGHT);
  assign blank_r =
    (state_q == OVER) && (winner_q == WIN_LEFT);

  score_seg7 u_seg_l (
    .digit (4'(score_l_q)),
    .blank (blank_l),
    .seg   (hexL)
  );

  score_seg7 u_seg_r (
    .digit (4'(score_r_q)),
    .blank (blank_r),
    .seg   (hexR)
  );

endmodule

// File: doc/victory_match.md
# victory_match

Match-level victory tracker for the tug-of-war game: a parametrised successor to the single-round victory detector. It sits between the playfield light chain and the seven-segment displays. It detects each round win from the edge lights and player presses, keeps a per-player score, and pauses between rounds before pulsing a playfield clear. It declares the match winner once a player reaches `WINS_TO_MATCH`.

## Interface
- `WINS_TO_MATCH`, default 3: round wins needed to take the match; legal range 1..9, because a score must fit one decimal digit.
- `HOLD_CYCLES`, default 4: length of the between-round pause in clock cycles; must be ≥1.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high; one clock; the only reset.
- `L` input 1: left player press; single-cycle pulse from the upstream input conditioner.
- `R` input 1: right player press; single-cycle pulse.
- `Llight` input 1: leftmost playfield light is on.
- `Rlight` input 1: rightmost playfield light is on.
- `round_clear` output 1: one-cycle pulse telling the playfield to recentre.
- `match_over` output 1: sticky; high once the match is decided.
- `winner` output 2: 2'b00 none, 2'b01 left, 2'b10 right; never 2'b11.
- `hexL` output 7: left score, active-low seven-segment.
- `hexR` output 7: right score, active-low seven-segment.

## Operation
- States: PLAY, HOLD, OVER. Reset puts the block in PLAY.
- **Round-win conditions**, evaluated only in PLAY:
  - Left win: `Llight & L & ~R`.
  - Right win: `Rlight & R & ~L`.
  - Both `L` and `R` high in the same cycle is never a win, whatever the lights show.
  - A press with only the opposite light on (`L`&`Rlight`, `R`&`Llight`) is no win.
- **On a win at edge k:**
  - The winner's score increments.
  - If the new score equals `WINS_TO_MATCH`, go to OVER: `winner` is set and `match_over` goes to 1.
  - Otherwise go to HOLD, with the hold counter loaded to `HOLD_CYCLES-1`.
- **HOLD:**
  - The counter decrements each cycle.
  - `round_clear` is high only in the HOLD cycle where the counter is 0.
  - The next edge returns to PLAY.
  - `L`, `R` and the lights are ignored throughout HOLD.
- **OVER:**
  - All inputs are ignored; scores, `winner` and `match_over` are frozen until `reset`.
  - `round_clear` stays 0.
- **Scores:** unsigned, width `$clog2(WINS_TO_MATCH+1)`; they can never exceed `WINS_TO_MATCH`, so no wrap-around.
- **Displays:**
  - `hexL` shows the decimal left score and `hexR` the right score.
  - In OVER, the loser's display is blank (7'b1111111); the winner's display keeps showing its score.
- **Reset** in any state, including mid-HOLD:
  - Next state PLAY, both scores 0, hold counter 0.
  - `round_clear` 0, `match_over` 0, `winner` 2'b00.
  - `hexL` = `hexR` = 7'b1000000 ("0").
  - `reset` has priority over a simultaneous win.

## Timing
- Inputs are sampled at the rising edge; a win qualifying before edge k updates score and state at edge k.
- `hexL`/`hexR` are decoded combinationally from the score registers, so they are visible in cycle k+1 (one-edge latency from press).
- `winner` and `match_over` are registered and also change at edge k.
- HOLD occupies exactly `HOLD_CYCLES` cycles, edges k through k+`HOLD_CYCLES`-1; `round_clear` is high in the last of them.
- PLAY resumes at edge k+`HOLD_CYCLES`, so a press in the cycle right after `round_clear` can score.
- `HOLD_CYCLES`=1: `round_clear` is high in the single HOLD cycle.
- `round_clear` is a Moore output; it is never asserted in PLAY or OVER.

## Structure
- Package `victory_pkg`:
  - State enum `vm_state_t` {PLAY, HOLD, OVER}.
  - Winner encodings `WIN_NONE`/`WIN_LEFT`/`WIN_RIGHT`.
  - Seven-segment constants `SEG_BLANK` and digits 0–9, active-low.
- Sub-module `score_seg7`: 4-bit digit plus blank input, 7-bit active-low segment output; instantiated twice.
- Top holds the FSM, hold counter, score registers and winner register.

## Test plan
All scenarios use `WINS_TO_MATCH`=3 and `HOLD_CYCLES`=4.
- **Left round win:** `Llight`=1, `L`=1, `R`=0 for one edge.
  - Score becomes L=1 and `hexL`=7'b1111001 ("1").
  - `round_clear` is high exactly in the 4th cycle after the win edge; PLAY then resumes.
- **Disallowed wins:** each of these, in PLAY, leaves both scores 0 and `round_clear` 0:
  - `L`=`R`=1 with `Llight`=1.
  - `L`=`R`=1 with `Rlight`=1.
  - `L`=1 with `Rlight`=1.
  - `R`=1 with `Llight`=1.
- **Inputs ignored in HOLD:** right win, then `Rlight`&`R` repeated during the 4 HOLD cycles → right score stays 1.
- **Match to right:**
  - Three right wins, separated by their holds, give `match_over`=1, `winner`=2'b10, `hexR`="3" and `hexL`=7'b1111111.
  - Further left wins change nothing.
- **Reset mid-HOLD:** `reset` on the 2nd HOLD cycle, after scores of 2–1.
  - Next cycle: scores 0–0, both hex = 7'b1000000, `round_clear` never pulses, state PLAY.
- **Reset over win:** `reset` and a left win in the same cycle → reset values only, score 0.
